wb_trace_buffer: RTL

Trace capture stage directly downstream of the `mips` core in the simulation harness. Each cycle it samples the core's architectural write events: GRF writebacks and data-memory stores. Accepted events are queued in a FIFO and presented through a valid/ready handshake to the trace checker, which compares them line by line against the reference-simulator trace. Loss conditions (overflow, simultaneous events) are flagged sticky rather than stalling the core, because the core has no stall input.

---
 rtl/wb_trace_buffer_if.sv | 19 +
 rtl/wb_trace_buffer.sv | 107 ++++++++++
 2 files changed

// File: rtl/wb_trace_buffer_if.sv
// Trace output stream: head entry of the capture FIFO presented with valid/ready.
interface wb_trace_buffer_if;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;

  modport master (
    output out_valid, out_kind, out_pc, out_addr, out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_kind, out_pc, out_addr, out_data,
    output out_ready
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Captures GRF writebacks and DM stores from the core into a FIFO for the trace checker.
// Never stalls the core: lost events are reported through sticky overflow/collide flags.
module wb_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int FILTER_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grf_we,
  input  logic [31:0]              grf_pc,
  input  logic [4:0]               grf_addr,
  input  logic [31:0]              grf_wd,
  input  logic                     dm_we,
  input  logic [31:0]              dm_pc,
  input  logic [31:0]              dm_addr,
  input  logic [31:0]              dm_wd,
  wb_trace_buffer_if.master        trace,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     collide,
  output logic [31:0]              event_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  entry_t         new_entry;
  entry_t         head;
  logic           grf_cand;
  logic           dm_cand;
  logic           full;
  logic           pop;
  logic           push;
  logic           drop;

  always_comb begin
    grf_cand = grf_we && ((FILTER_ZERO == 0) || (grf_addr != 5'd0));
    dm_cand  = dm_we;
    full     = (count == CW'(DEPTH));
    pop      = (count != '0) && trace.out_ready;
    // A pop on a full FIFO frees the slot in time for this cycle's event.
    push     = (grf_cand || dm_cand) && (!full || pop);
    drop     = (grf_cand || dm_cand) && full && !pop;
    if (grf_cand) begin
      new_entry = '{kind: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wd};
    end else begin
      new_entry = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wd};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      collide   <= 1'b0;
      event_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        event_cnt <= event_cnt + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
      if (grf_cand && dm_cand) begin
        collide <= 1'b1;
      end
    end
  end

  // Head is read straight from memory; stale contents while empty are harmless.
  always_comb begin
    head            = mem[rd_ptr];
    trace.out_valid = (count != '0);
    trace.out_kind  = head.kind;
    trace.out_pc    = head.pc;
    trace.out_addr  = head.addr;
    trace.out_data  = head.data;
  end

endmodule
